mem_access: RTL and testbench

Memory-access (MEM) stage of the EPU RV32I pipeline. It consumes the registered request held by the EX→MEM pipeline register and performs loads and stores over the byte-serial RAM port. It raises a stall request so the upstream register holds its contents while the multi-byte access runs. It then presents the write-back triple (`wb_forward`, `wb_rd_addr`, `wb_rd_val`) registered to the WB side.

---
 rtl/epu_defs.sv | 49 ++++
 rtl/mem_load_ext.sv | 29 ++
 rtl/mem_access.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/epu_defs.sv
// ============================================================================
// Module : epu_defs
// Brief  : Shared EPU RV32I constants: opcodes, funct3 codes, MEM FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package epu_defs;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Index of the final byte of an access: 0, 1 or 3 (unused codes act as words).
  function automatic logic [1:0] last_byte_idx(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [31:0] addr);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr[0];
      default: return addr[1:0] != 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_ext.sv
// ============================================================================
// Module : mem_load_ext
// Brief  : Sign/zero extension of an assembled load word according to funct3.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_load_ext
  import epu_defs::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = word_i;
    case (funct3_i)
      F3_LB:   result_o = {{24{word_i[7]}}, word_i[7:0]};
      F3_LH:   result_o = {{16{word_i[15]}}, word_i[15:0]};
      F3_LBU:  result_o = {24'h000000, word_i[7:0]};
      F3_LHU:  result_o = {16'h0000, word_i[15:0]};
      default: result_o = word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module : mem_access
// Brief  : RV32I MEM stage; byte-serial loads/stores with upstream stall.
//          Optional MEM_ACCESS_MISALIGN_CHECK_EN adds the misalign output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_access
  import epu_defs::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        forward,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_val,
  input  logic [6:0]  ins_type,
  input  logic [2:0]  ins_details,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_val,
  output logic        stall_req,
  output logic        wb_forward,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_val,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        wbf_q, wbf_d;
  logic [4:0]  wba_q, wba_d;
  logic [31:0] wbv_q, wbv_d;

  logic        is_load, is_store, mis_w;
  logic [1:0]  last_idx, load_end, byte_sel;
  logic [31:0] asm_merged, ext_result;

  assign is_load  = (ins_type == OP_LOAD);
  assign is_store = (ins_type == OP_STORE);
  assign last_idx = last_byte_idx(ins_details);
  assign load_end = last_idx + 2'd1;
  assign byte_sel = cnt_q - 2'd1;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  assign mis_w = is_misaligned(ins_details, mem_addr);
`else
  assign mis_w = 1'b0;
`endif

  // The byte arriving this cycle is merged in so the final extension sees it.
  always_comb begin
    asm_merged = asm_q;
    asm_merged[{byte_sel, 3'b000} +: 8] = mem_din;
  end

  mem_load_ext u_ext (
    .funct3_i (ins_details),
    .word_i   (asm_merged),
    .result_o (ext_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    wbf_d     = wbf_q;
    wba_d     = wba_q;
    wbv_d     = wbv_q;
    stall_req = 1'b0;
    mem_a     = ZeroWord;
    mem_dout  = 8'h00;
    mem_wr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_load || is_store) begin
          stall_req = 1'b1;
          if (mis_w) begin
            wbf_d   = 1'b0;
            wba_d   = rd_addr;
            wbv_d   = rd_val;
            state_d = ST_DONE;
          end else if (is_load) begin
            mem_a   = mem_addr;
            cnt_d   = 2'd1;
            state_d = ST_RD;
          end else begin
            mem_a    = mem_addr;
            mem_dout = mem_val[7:0];
            mem_wr   = 1'b1;
            if (last_idx == 2'd0) begin
              wbf_d   = 1'b0;
              wba_d   = rd_addr;
              wbv_d   = rd_val;
              state_d = ST_DONE;
            end else begin
              cnt_d   = 2'd1;
              state_d = ST_WR;
            end
          end
        end else begin
          wbf_d = forward;
          wba_d = rd_addr;
          wbv_d = rd_val;
        end
      end
      ST_RD: begin
        stall_req = 1'b1;
        asm_d     = asm_merged;
        // A 4-byte load wraps cnt to 0 on its final byte.
        if (cnt_q != load_end) begin
          mem_a = mem_addr + {30'd0, cnt_q};
          cnt_d = cnt_q + 2'd1;
        end else begin
          wbf_d   = forward;
          wba_d   = rd_addr;
          wbv_d   = ext_result;
          state_d = ST_DONE;
        end
      end
      ST_WR: begin
        stall_req = 1'b1;
        mem_a     = mem_addr + {30'd0, cnt_q};
        mem_dout  = mem_val[{cnt_q, 3'b000} +: 8];
        mem_wr    = 1'b1;
        if (cnt_q == last_idx) begin
          wbf_d   = 1'b0;
          wba_d   = rd_addr;
          wbv_d   = rd_val;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // While frozen, keep requesting the byte that the resume cycle will capture.
    if (!rdy_in) begin
      mem_wr = 1'b0;
      if (state_q == ST_RD) begin
        mem_a = mem_addr + {30'd0, byte_sel};
      end
    end

    if (rst_in) begin
      stall_req = 1'b0;
      mem_a     = ZeroWord;
      mem_dout  = 8'h00;
      mem_wr    = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      asm_q   <= ZeroWord;
      wbf_q   <= 1'b0;
      wba_q   <= 5'd0;
      wbv_q   <= ZeroWord;
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      wbf_q   <= wbf_d;
      wba_q   <= wba_d;
      wbv_q   <= wbv_d;
    end
  end

  assign wb_forward = wbf_q;
  assign wb_rd_addr = wba_q;
  assign wb_rd_val  = wbv_q;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mis_q <= 1'b0;
    end else if (rdy_in) begin
      mis_q <= (state_q == ST_IDLE) && (is_load || is_store) && mis_w;
    end
  end

  assign misalign = mis_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module : tb_mem_access
// Brief  : Self-checking bench for mem_access: directed table, reset abort,
//          randomized ops against a byte-array memory model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_ADDI  = 7'b0010011;
  localparam logic [6:0] T_ALU   = 7'b0110011;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, forward;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val;
  logic [6:0]  ins_type;
  logic [2:0]  ins_details;
  logic [31:0] mem_addr, mem_val;
  logic        stall_req, wb_forward;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_val;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  mem_access dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .forward     (forward),
    .rd_addr     (rd_addr),
    .rd_val      (rd_val),
    .ins_type    (ins_type),
    .ins_details (ins_details),
    .mem_addr    (mem_addr),
    .mem_val     (mem_val),
    .stall_req   (stall_req),
    .wb_forward  (wb_forward),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_val   (wb_rd_val),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_a       (mem_a),
    .mem_wr      (mem_wr)
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    ,
    .misalign    (misalign)
`endif
  );

  // Initial memory image; the named addresses hold the directed test bytes.
  function automatic logic [7:0] init_byte(input logic [9:0] a);
    case (a)
      10'h100: return 8'h78;
      10'h101: return 8'h56;
      10'h102: return 8'h34;
      10'h103: return 8'h12;
      10'h200: return 8'h80;
      10'h000: return 8'h00;
      10'h001: return 8'h80;
      default: return a[7:0] ^ {6'd0, a[9:8]} ^ 8'hA5;
    endcase
  endfunction

  // RAM seen by the DUT: 1 KiB window addressed by mem_a[9:0], 1-cycle read.
  logic [7:0] ram [1024];
  logic       ram_init;
  always @(posedge clk_in) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(10'(i));
    end else if (mem_wr) begin
      ram[mem_a[9:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[9:0]];
  end

  // Reference memory contents, updated by the model on every store.
  logic [7:0] gold [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] w);
    int v;
    case (f3)
      3'b000: begin v = int'(w & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
      3'b001: begin v = int'(w & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
      3'b100: return w & 32'hFF;
      3'b101: return w & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // Presents one instruction, follows it to completion and checks everything
  // against the model. Called #1 after a rising edge; returns likewise.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] val,
                        input logic [31:0] rdv, input logic [4:0] rd, input logic fwd,
                        input int frz_at, input int frz_len,
                        output logic [31:0] got_val, output logic mis);
    int n, exp_stall, exp_nwr, nst, nwr;
    logic is_ld, is_st, exp_fwd, wr_frozen, done, mis_seen;
    logic [31:0] exp_val, w, a;
    logic [31:0] rd_a [4];
    logic [31:0] wr_a [4];
    logic [7:0]  wr_d [4];

    n     = nbytes(f3);
    is_ld = (op == T_LOAD);
    is_st = (op == T_STORE);
    mis   = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    mis = (is_ld || is_st) && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
`endif
    exp_nwr = 0;
    exp_val = rdv;
    exp_fwd = fwd;
    if (mis) begin
      exp_stall = 1;
      exp_fwd   = 1'b0;
    end else if (is_ld) begin
      exp_stall = n + 1;
      w = 32'd0;
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        w = w | (32'(gold[a[9:0]]) << (8 * i));
      end
      exp_val = load_value(f3, w);
    end else if (is_st) begin
      exp_stall = n;
      exp_nwr   = n;
      exp_fwd   = 1'b0;
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        gold[a[9:0]] = val[8*i +: 8];
      end
    end else begin
      exp_stall = 0;
    end

    ins_type = op; ins_details = f3; mem_addr = addr; mem_val = val;
    rd_val = rdv; rd_addr = rd; forward = fwd;
    nst = 0; nwr = 0; wr_frozen = 1'b0; done = 1'b0; mis_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin rd_a[i] = 32'd0; wr_a[i] = 32'd0; wr_d[i] = 8'd0; end

    for (int t = 0; t < 40 && !done; t++) begin
      rdy_in = !(t >= frz_at && t < frz_at + frz_len);
      @(negedge clk_in);
      if (!rdy_in) begin
        if (mem_wr) wr_frozen = 1'b1;
      end else begin
        if (mem_wr) begin
          if (nwr < 4) begin wr_a[nwr] = mem_a; wr_d[nwr] = mem_dout; end
          nwr++;
        end
        if (stall_req) begin
          if (nst < 4) rd_a[nst] = mem_a;
          nst++;
        end else begin
          done = 1'b1;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
          mis_seen = misalign;
`endif
        end
      end
      @(posedge clk_in); #1;
    end
    rdy_in = 1'b1;

    chk("op_completed", 32'(done), 32'd1);
    chk("stall_cycles", 32'(nst), 32'(exp_stall));
    chk("write_count", 32'(nwr), 32'(exp_nwr));
    chk("no_write_while_frozen", 32'(wr_frozen), 32'd0);
    chk("misalign_flag", 32'(mis_seen), 32'(mis));
    if (mis) chk("misaligned_no_addr", rd_a[0], 32'd0);
    if (is_ld && !mis) begin
      for (int i = 0; i < n; i++) chk("load_addr", rd_a[i], addr + 32'(i));
    end
    if (is_st && !mis && nwr == n) begin
      for (int i = 0; i < n; i++) begin
        chk("store_addr", wr_a[i], addr + 32'(i));
        chk("store_data", 32'(wr_d[i]), 32'(val[8*i +: 8]));
      end
    end
    chk("wb_forward", 32'(wb_forward), 32'(exp_fwd));
    if (!is_st && !mis) begin
      chk("wb_rd_addr", 32'(wb_rd_addr), 32'(rd));
      chk("wb_rd_val", wb_rd_val, exp_val);
    end
    got_val = wb_rd_val;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] val;
    logic [31:0] rdv;
    logic [4:0]  rd;
    logic        fwd;
    int          frz_at;
    int          frz_len;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [31:0] got;
    logic        mis;
    logic [6:0]  op;
    int          sel;

    vt[0] = '{T_ADDI,  3'b000, 32'h0000_0000, 32'h0,          32'h0000_1234, 5'd5, 1'b1, 99, 0, 32'h0000_1234};
    vt[1] = '{T_LOAD,  3'b010, 32'h0000_0100, 32'h0,          32'h0,         5'd6, 1'b1, 99, 0, 32'h1234_5678};
    vt[2] = '{T_LOAD,  3'b000, 32'h0000_0200, 32'h0,          32'h0,         5'd7, 1'b1, 99, 0, 32'hFFFF_FF80};
    vt[3] = '{T_LOAD,  3'b100, 32'h0000_0200, 32'h0,          32'h0,         5'd8, 1'b1, 99, 0, 32'h0000_0080};
    vt[4] = '{T_LOAD,  3'b001, 32'h0000_0000, 32'h0,          32'h0,         5'd9, 1'b1, 99, 0, 32'hFFFF_8000};
    vt[5] = '{T_STORE, 3'b001, 32'h0000_0010, 32'hAABB_CCDD,  32'h0,         5'd3, 1'b1, 99, 0, 32'h0};
    vt[6] = '{T_LOAD,  3'b101, 32'h0000_0010, 32'h0,          32'h0,         5'd4, 1'b1, 99, 0, 32'h0000_CCDD};
    vt[7] = '{T_STORE, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344,  32'h0,         5'd1, 1'b1, 2,  3, 32'h0};
    vt[8] = '{T_LOAD,  3'b010, 32'hFFFF_FFFE, 32'h0,          32'h0,         5'd2, 1'b1, 99, 0, 32'h1122_3344};
    vt[9] = '{T_LOAD,  3'b010, 32'h0000_0100, 32'h0,          32'h0,         5'd3, 1'b1, 2,  2, 32'h1234_5678};

    for (int i = 0; i < 1024; i++) gold[i] = init_byte(10'(i));
    rst_in = 1'b1; ram_init = 1'b1; rdy_in = 1'b1; forward = 1'b0; rd_addr = 5'd0;
    rd_val = 32'd0; ins_type = 7'd0; ins_details = 3'd0; mem_addr = 32'd0; mem_val = 32'd0;
    repeat (3) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    chk("reset_stall_req", 32'(stall_req), 32'd0);
    chk("reset_wb_forward", 32'(wb_forward), 32'd0);
    chk("reset_wb_rd_addr", 32'(wb_rd_addr), 32'd0);
    chk("reset_wb_rd_val", wb_rd_val, 32'd0);
    chk("reset_mem_wr", 32'(mem_wr), 32'd0);
    chk("reset_mem_a", mem_a, 32'd0);
    chk("reset_mem_dout", 32'(mem_dout), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0; ram_init = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].f3, vt[i].addr, vt[i].val, vt[i].rdv, vt[i].rd, vt[i].fwd,
             vt[i].frz_at, vt[i].frz_len, got, mis);
      if (vt[i].op != T_STORE && !mis) chk("table_result", got, vt[i].exp_val);
    end

    // Reset in the middle of a word load aborts it and clears write-back.
    ins_type = T_LOAD; ins_details = 3'b010; mem_addr = 32'h0000_0100;
    rd_addr = 5'd12; forward = 1'b1; rdy_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("rst_mid_stall", 32'(stall_req), 32'd0);
    chk("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0; ins_type = T_ADDI; forward = 1'b0;
    @(negedge clk_in);
    chk("rst_mid_idle_stall", 32'(stall_req), 32'd0);
    chk("rst_mid_wb_forward", 32'(wb_forward), 32'd0);
    chk("rst_mid_wb_rd_addr", 32'(wb_rd_addr), 32'd0);
    chk("rst_mid_wb_rd_val", wb_rd_val, 32'd0);
    @(posedge clk_in); #1;

    for (int k = 0; k < 150; k++) begin
      logic [31:0] ra;
      int fa, fl;
      sel = $urandom_range(0, 2);
      op  = (sel == 0) ? (($urandom_range(0, 1) == 0) ? T_ADDI : T_ALU)
                       : ((sel == 1) ? T_LOAD : T_STORE);
      ra  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63))
                                        : 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        fa = $urandom_range(0, 4);
        fl = $urandom_range(1, 3);
      end else begin
        fa = 99;
        fl = 0;
      end
      run_op(op, 3'($urandom_range(0, 7)), ra, $urandom, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), fa, fl, got, mis);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
